// File: rtl/npc_defs.sv
// npc_defs: definitions shared by the NPC load/store path.
//   - MEM_OP_* : decoder mem_op encodings that are legal (bits [1:0] give the
//                size, bit [2] selects zero-extension)
//   - lsu_state_e : 2-bit LSU state encoding
//   - op_legal / is_misaligned : decode helpers used by the LSU front end
// No ports (package).
package npc_defs;

    localparam logic [2:0] MEM_OP_LB  = 3'b000;
    localparam logic [2:0] MEM_OP_LH  = 3'b001;
    localparam logic [2:0] MEM_OP_LW  = 3'b010;
    localparam logic [2:0] MEM_OP_LBU = 3'b100;
    localparam logic [2:0] MEM_OP_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Only meaningful for legal ops: half needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b01:   return off[0];
            2'b10:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
//   op_i       [2:0]  mem_op (size in [1:0], unsigned in [2])
//   off_i      [1:0]  byte offset within the word
//   rdata_i    [31:0] raw read word from the bus
//   wdata_i    [31:0] store data (rs2)
//   ld_data_o  [31:0] extracted and sign/zero-extended load data
//   st_wdata_o [31:0] store data shifted onto its byte lanes
//   st_wmask_o [3:0]  byte strobes for the store
// Offset bits below the access size are ignored (half uses off_i[1] only,
// word ignores the offset), which gives forced alignment for free.
module lsu_align
    import npc_defs::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wmask_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(rdata_i >> {off_i, 3'b000});
        half_v = 16'(rdata_i >> {off_i[1], 4'b0000});
        case (op_i[1:0])
            2'b00:   ld_data_o = op_i[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   ld_data_o = op_i[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: ld_data_o = rdata_i;
        endcase
    end

    always_comb begin
        case (op_i[1:0])
            2'b00: begin
                st_wmask_o = 4'b0001 << off_i;
                st_wdata_o = {24'b0, wdata_i[7:0]} << {off_i, 3'b000};
            end
            2'b01: begin
                st_wmask_o = 4'b0011 << {off_i[1], 1'b0};
                st_wdata_o = {16'b0, wdata_i[15:0]} << {off_i[1], 4'b0000};
            end
            default: begin
                st_wmask_o = 4'b1111;
                st_wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit of the NPC core. Accepts one instruction from EXU,
// runs at most one bus transaction for it, returns the result to WBU.
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          instruction handshake (addr, wdata, rd_en, wr_en, op)
//   out_valid/out_ready        result handshake (out_rdata, out_err)
//   mem_req_*                  request channel (addr, wen, wdata, wmask)
//   mem_resp_*                 response channel (rdata, err)
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses fault without touching the bus; otherwise they are forced aligned.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for an instruction
// ST_REQ  | request presented, waiting for mem_req_ready
// ST_RESP | waiting for mem_resp_valid
// ST_DONE | result presented, waiting for out_ready
module lsu
    import npc_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_rd_en,
    input  logic              in_wr_en,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_err
);

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        op_q;
    logic              wr_q;
    logic              in_ready_q;
    logic              req_valid_q;
    logic              resp_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_rdata_q;
    logic              out_err_q;

    logic [31:0]       ld_data;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wmask;
    logic              misalign_trap;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_trap = is_misaligned(in_op, in_addr[1:0]);
`else
    assign misalign_trap = 1'b0;
`endif

    // Steering works off the registered instruction, so request fields stay
    // constant from REQ until the handshake and loads see the accepted op.
    lsu_align u_align (
        .op_i       (op_q),
        .off_i      (addr_q[1:0]),
        .rdata_i    (mem_resp_rdata),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_wdata_o (st_wdata),
        .st_wmask_o (st_wmask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= '0;
            wr_q         <= 1'b0;
            in_ready_q   <= 1'b1;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_rdata_q  <= '0;
            out_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        addr_q     <= in_addr;
                        wdata_q    <= in_wdata;
                        op_q       <= in_op;
                        wr_q       <= in_wr_en;
                        in_ready_q <= 1'b0;
                        if (!in_rd_en && !in_wr_en) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_rdata_q <= '0;
                            out_err_q   <= 1'b0;
                        end else if ((in_rd_en && in_wr_en) || !op_legal(in_op) || misalign_trap) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_rdata_q <= '0;
                            out_err_q   <= 1'b1;
                        end else begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state_q      <= ST_RESP;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        state_q      <= ST_DONE;
                        resp_ready_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_rdata_q  <= wr_q ? '0 : ld_data;
                        out_err_q    <= mem_resp_err;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_rdata      = out_rdata_q;
    assign out_err        = out_err_q;
    assign mem_req_valid  = req_valid_q;
    assign mem_req_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_req_wen    = wr_q;
    assign mem_req_wdata  = st_wdata;
    assign mem_req_wmask  = wr_q ? st_wmask : 4'b0000;
    assign mem_resp_ready = resp_ready_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_addr, in_wdata;
    logic        in_rd_en, in_wr_en;
    logic [2:0]  in_op;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_rd_en       (in_rd_en),
        .in_wr_en       (in_wr_en),
        .in_op          (in_op),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_err        (out_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int acc_bytes(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal_op(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    endfunction

    // Byte offset actually used: round the address offset down to the access size.
    function automatic int lane_off(input logic [31:0] addr, input logic [2:0] op);
        int sz = acc_bytes(op);
        int a  = int'(addr % 4);
        return (a / sz) * sz;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        longint sz  = longint'(acc_bytes(op));
        longint v   = longint'({32'b0, word}) >> (8 * lane_off(addr, op));
        longint lim = 64'd1 << (8 * sz);
        v = v % lim;
        if (op < 3'd4 && sz < 4 && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    function automatic logic [3:0] ref_wmask(input logic [2:0] op, input logic [31:0] addr);
        int sz = acc_bytes(op);
        return 4'(((1 << sz) - 1) << lane_off(addr, op));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] wd);
        longint sz = longint'(acc_bytes(op));
        longint v  = longint'({32'b0, wd}) % (64'd1 << (8 * sz));
        return 32'(v * (64'd1 << (8 * lane_off(addr, op))));
    endfunction

    // ---------------- one instruction, fixed-cycle protocol ----------------
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input bit rd,
                           input bit wr, input logic [2:0] op, input logic [31:0] word,
                           input bit rerr, input int req_dly, input int resp_dly,
                           input int out_dly);
        bit          bus;
        bit          exp_err;
        logic [31:0] exp_rdata;
        if (!rd && !wr) begin
            bus = 0; exp_err = 0; exp_rdata = 0;
        end else if ((rd && wr) || !legal_op(op) ||
                     (TRAP_EN && (int'(addr % 4) % acc_bytes(op)) != 0)) begin
            bus = 0; exp_err = 1; exp_rdata = 0;
        end else begin
            bus = 1; exp_err = rerr; exp_rdata = wr ? 32'd0 : ref_load(op, addr, word);
        end

        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_addr = addr; in_wdata = wd; in_rd_en = rd; in_wr_en = wr; in_op = op;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_addr = $urandom; in_wdata = $urandom; in_op = 3'($urandom);
        in_rd_en = 1'($urandom); in_wr_en = 1'($urandom);

        if (!bus) begin
            check("noreq_valid", 32'(mem_req_valid), 32'd0);
        end else begin
            for (int i = 0; i <= req_dly; i++) begin
                check("req_valid", 32'(mem_req_valid), 32'd1);
                check("req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
                check("req_wen", 32'(mem_req_wen), 32'(wr));
                check("req_wmask", 32'(mem_req_wmask), wr ? 32'(ref_wmask(op, addr)) : 32'd0);
                if (wr) check("req_wdata", mem_req_wdata, ref_wdata(op, addr, wd));
                check("resp_rdy_req", 32'(mem_resp_ready), 32'd0);
                check("in_ready_busy", 32'(in_ready), 32'd0);
                if (i == req_dly) mem_req_ready = 1'b1;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
            end
            check("req_drop", 32'(mem_req_valid), 32'd0);
            for (int i = 0; i < resp_dly; i++) begin
                check("resp_rdy_wait", 32'(mem_resp_ready), 32'd1);
                check("out_valid_wait", 32'(out_valid), 32'd0);
                @(posedge clk); #1;
            end
            check("resp_rdy", 32'(mem_resp_ready), 32'd1);
            mem_resp_valid = 1'b1; mem_resp_rdata = word; mem_resp_err = rerr;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'($urandom);
        end

        for (int i = 0; i <= out_dly; i++) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_rdata", out_rdata, exp_rdata);
            check("out_err", 32'(out_err), 32'(exp_err));
            check("in_ready_done", 32'(in_ready), 32'd0);
            check("req_valid_done", 32'(mem_req_valid), 32'd0);
            if (i == out_dly) out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_rdata", out_rdata, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
        check("rst_req_wen", 32'(mem_req_wen), 32'd0);
        check("rst_req_wdata", mem_req_wdata, 32'd0);
        check("rst_req_wmask", 32'(mem_req_wmask), 32'd0);
        check("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_addr;
        int          kind;
        bit          r_rd, r_wr;

        rst_n = 1'b0; in_valid = 0; in_addr = 0; in_wdata = 0; in_rd_en = 0; in_wr_en = 0;
        in_op = 0; out_ready = 0; mem_req_ready = 0; mem_resp_valid = 0;
        mem_resp_rdata = 0; mem_resp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // directed cases
        run_txn(32'h8000_0003, 32'h0, 1, 0, 3'b000, 32'h80FF_0102, 0, 0, 0, 0);
        run_txn(32'h8000_0002, 32'h0, 1, 0, 3'b101, 32'h8001_ABCD, 0, 0, 0, 0);
        run_txn(32'h8000_0001, 32'h1234_56AB, 0, 1, 3'b000, 32'hDEAD_BEEF, 0, 0, 0, 0);
        run_txn(32'h8000_0006, 32'hCAFE_F00D, 0, 1, 3'b001, 32'h0, 0, 3, 1, 2);
        run_txn(32'h8000_0010, 32'h0, 1, 0, 3'b010, 32'h1357_9BDF, 1, 3, 0, 2);
        run_txn(32'h8000_0000, 32'h0, 1, 0, 3'b011, 32'h0, 0, 0, 0, 0);
        run_txn(32'h8000_0000, 32'h0, 1, 1, 3'b010, 32'h0, 0, 0, 0, 0);
        run_txn(32'h8000_0004, 32'h0, 0, 0, 3'b010, 32'h0, 0, 0, 0, 1);
        run_txn(32'h8000_0001, 32'h0, 1, 0, 3'b001, 32'h8001_ABCD, 0, 0, 0, 0);
        run_txn(32'h8000_0003, 32'h0, 1, 0, 3'b010, 32'h8001_ABCD, 0, 0, 0, 0);

        // reset while waiting for a response, then a stale response
        in_addr = 32'h8000_0008; in_wdata = 0; in_rd_en = 1; in_wr_en = 0; in_op = 3'b010;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_rd_en = 0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("mid_resp_ready", 32'(mem_resp_ready), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_outputs();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stale_out_valid", 32'(out_valid), 32'd0);
            check("stale_resp_rdy", 32'(mem_resp_ready), 32'd0);
        end
        mem_resp_valid = 1'b0;
        run_txn(32'h8000_0008, 32'h0, 1, 0, 3'b010, 32'h0BAD_F00D, 0, 0, 0, 0);

        // response offered early while the request is still pending must wait
        // (covered implicitly by RESP-only acceptance); now randomized traffic
        for (int n = 0; n < 250; n++) begin
            kind   = $urandom_range(0, 11);
            r_rd   = (kind >= 2) ? (kind % 2 == 0) : (kind == 1);
            r_wr   = (kind >= 2) ? (kind % 2 == 1) : (kind == 1);
            r_op   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 4));
            if (r_op == 3'd3) r_op = 3'd5;
            r_addr = $urandom;
            run_txn(r_addr, $urandom, r_rd, r_wr, r_op, $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
